// File: rtl/fc_pkg.sv
// Shared types, default widths and saturation helper for the FC psum reducer.
package fc_pkg;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_ACCUM = 2'd1,
    FC_DRAIN = 2'd2
  } fc_state_e;

  localparam int unsigned FC_PSUM_W    = 16;
  localparam int unsigned FC_ACC_W     = 24;
  localparam int unsigned FC_OUT_W     = 8;
  localparam int unsigned FC_MAX_NODES = 128;
  localparam int unsigned FC_MAX_TILES = 8;
  localparam int unsigned FC_SHIFT_W   = 4;

  // Clamp a 64-bit signed value into the signed range of `width` bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/fc_out_fifo.sv
// Two-entry result FIFO; the head entry is a register that directly drives the output.
module fc_out_fifo #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready_c,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count_c
);

  logic [W-1:0] head_q, tail_q;
  logic         head_v, tail_v;
  logic         push, pop;

  assign in_ready_c = !tail_v || out_ready;
  assign push       = in_valid && in_ready_c;
  assign pop        = head_v && out_ready;
  assign count_c    = 2'(head_v) + 2'(tail_v);
  assign out_data   = head_q;
  assign out_valid  = head_v;

  // Tail only fills when head is occupied; a pop promotes tail into head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      head_v <= 1'b0;
      tail_v <= 1'b0;
    end else if (pop) begin
      if (tail_v) begin
        head_q <= tail_q;
        if (push) tail_q <= in_data;
        else      tail_v <= 1'b0;
      end else if (push) begin
        head_q <= in_data;
      end else begin
        head_v <= 1'b0;
      end
    end else if (push) begin
      if (!head_v) begin
        head_q <= in_data;
        head_v <= 1'b1;
      end else begin
        tail_q <= in_data;
        tail_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_psum_reducer.sv
// FC partial-sum accumulate across tiles, requantise (round/shift/saturate) and stream out.
// Optional ReLU is compiled in when FC_RELU_EN is defined.
module fc_psum_reducer
  import fc_pkg::*;
#(
  parameter int unsigned PSUM_W    = FC_PSUM_W,
  parameter int unsigned ACC_W     = FC_ACC_W,
  parameter int unsigned OUT_W     = FC_OUT_W,
  parameter int unsigned MAX_NODES = FC_MAX_NODES,
  parameter int unsigned MAX_TILES = FC_MAX_TILES,
  parameter int unsigned SHIFT_W   = FC_SHIFT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start_i,
  input  logic [$clog2(MAX_NODES+1)-1:0]       cfg_node_num_i,
  input  logic [$clog2(MAX_TILES+1)-1:0]       cfg_tile_num_i,
  input  logic [SHIFT_W-1:0]                   cfg_shift_i,
  input  logic                                 cfg_relu_i,
  input  logic signed [PSUM_W-1:0]             psum_i,
  input  logic                                 psum_valid_i,
  output logic                                 psum_ready_o,
  output logic signed [OUT_W-1:0]              res_o,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic                                 res_last_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int unsigned NODE_W = $clog2(MAX_NODES + 1);
  localparam int unsigned TILE_W = $clog2(MAX_TILES + 1);
  localparam int unsigned IDX_W  = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  fc_state_e state_q, state_nx;

  logic [NODE_W-1:0]  node_n_q, node_cnt_q, node_n_nx, node_cnt_nx;
  logic [TILE_W-1:0]  tile_n_q, tile_cnt_q, tile_n_nx, tile_cnt_nx;
  logic [SHIFT_W-1:0] shift_q;
  logic               busy_q, done_q, err_q, ready_q;
  logic               busy_nx, done_nx, err_nx, ready_nx;

  logic signed [ACC_W-1:0] acc_q [MAX_NODES];
  logic signed [ACC_W-1:0] acc_rd;
  logic signed [63:0]      sum64, acc_v, rounded, shifted;
  logic signed [OUT_W-1:0] res_c;

  logic             psum_fire, last_node, final_tile, final_nx, start_ok, drain_done;
  logic             fifo_push, fifo_pop, fifo_in_ready_c;
  logic [1:0]       fifo_count_c;
  logic [2:0]       cnt_nx;
  logic [OUT_W:0]   fifo_out;

`ifdef FC_RELU_EN
  logic relu_q;
`else
  logic unused_relu;
  assign unused_relu = cfg_relu_i;
`endif

  assign psum_fire  = psum_valid_i && ready_q;
  assign last_node  = node_cnt_q == node_n_q - NODE_W'(1);
  assign final_tile = tile_cnt_q == tile_n_q - TILE_W'(1);
  assign start_ok   = cfg_start_i && !busy_q && (state_q == FC_IDLE) &&
                      (cfg_node_num_i != '0) && (cfg_tile_num_i != '0);
  assign fifo_pop   = res_valid_o && res_ready_i;
  assign drain_done = (state_q == FC_DRAIN) && fifo_pop && res_last_o;
  assign fifo_push  = psum_fire && final_tile && fifo_in_ready_c;

  // Accumulate path and requantisation of the final-tile value.
  always_comb begin
    acc_rd  = acc_q[IDX_W'(node_cnt_q)];
    sum64   = 64'(psum_i) + 64'(acc_rd);
    acc_v   = sat_signed((tile_cnt_q == '0) ? 64'(psum_i) : sum64, ACC_W);
    rounded = acc_v;
    if (shift_q != '0)
      rounded = sat_signed(acc_v + (64'sd1 <<< (shift_q - SHIFT_W'(1))), ACC_W);
    shifted = rounded >>> shift_q;
    res_c   = OUT_W'(sat_signed(shifted, OUT_W));
`ifdef FC_RELU_EN
    if (relu_q && res_c[OUT_W-1]) res_c = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (psum_fire && !final_tile) acc_q[IDX_W'(node_cnt_q)] <= ACC_W'(acc_v);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FC_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      FC_IDLE:  if (start_ok) state_nx = FC_ACCUM;
      FC_ACCUM: if (psum_fire && final_tile && last_node) state_nx = FC_DRAIN;
      FC_DRAIN: if (drain_done) state_nx = FC_IDLE;
      default:  state_nx = FC_IDLE;
    endcase
  end

  // Counter/config next values and next-cycle registered outputs.
  always_comb begin
    node_cnt_nx = node_cnt_q;
    tile_cnt_nx = tile_cnt_q;
    node_n_nx   = node_n_q;
    tile_n_nx   = tile_n_q;
    if (start_ok) begin
      node_cnt_nx = '0;
      tile_cnt_nx = '0;
      node_n_nx   = cfg_node_num_i;
      tile_n_nx   = cfg_tile_num_i;
    end else if (psum_fire) begin
      if (last_node) begin
        node_cnt_nx = '0;
        if (!final_tile) tile_cnt_nx = tile_cnt_q + TILE_W'(1);
      end else begin
        node_cnt_nx = node_cnt_q + NODE_W'(1);
      end
    end
    cnt_nx   = 3'(fifo_count_c) + 3'(fifo_push) - 3'(fifo_pop);
    final_nx = tile_cnt_nx == tile_n_nx - TILE_W'(1);
    ready_nx = (state_nx == FC_ACCUM) && (!final_nx || (cnt_nx < 3'd2));
    done_nx  = drain_done;
    busy_nx  = (state_nx != FC_IDLE) || done_nx;
    err_nx   = (cfg_start_i && !start_ok) || (psum_valid_i && (state_q != FC_ACCUM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      node_cnt_q <= '0;
      tile_cnt_q <= '0;
      node_n_q   <= '0;
      tile_n_q   <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
`ifdef FC_RELU_EN
      relu_q     <= 1'b0;
`endif
    end else begin
      node_cnt_q <= node_cnt_nx;
      tile_cnt_q <= tile_cnt_nx;
      node_n_q   <= node_n_nx;
      tile_n_q   <= tile_n_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      err_q      <= err_nx;
      ready_q    <= ready_nx;
      if (start_ok) begin
        shift_q <= cfg_shift_i;
`ifdef FC_RELU_EN
        relu_q  <= cfg_relu_i;
`endif
      end
    end
  end

  fc_out_fifo #(.W(OUT_W + 1)) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_data    ({last_node, res_c}),
    .in_valid   (psum_fire && final_tile),
    .in_ready_c (fifo_in_ready_c),
    .out_data   (fifo_out),
    .out_valid  (res_valid_o),
    .out_ready  (res_ready_i),
    .count_c    (fifo_count_c)
  );

  assign res_o        = fifo_out[OUT_W-1:0];
  assign res_last_o   = fifo_out[OUT_W];
  assign psum_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fc_psum_reducer.sv
// Directed bench for fc_psum_reducer with a result scoreboard and immediate assertions.
module tb_fc_psum_reducer;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start_i;
  logic [7:0]        cfg_node_num_i;
  logic [3:0]        cfg_tile_num_i;
  logic [3:0]        cfg_shift_i;
  logic              cfg_relu_i;
  logic signed [15:0] psum_i;
  logic              psum_valid_i;
  logic              psum_ready_o;
  logic signed [7:0] res_o;
  logic              res_valid_o;
  logic              res_ready_i;
  logic              res_last_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  fc_psum_reducer dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start_i    (cfg_start_i),
    .cfg_node_num_i (cfg_node_num_i),
    .cfg_tile_num_i (cfg_tile_num_i),
    .cfg_shift_i    (cfg_shift_i),
    .cfg_relu_i     (cfg_relu_i),
    .psum_i         (psum_i),
    .psum_valid_i   (psum_valid_i),
    .psum_ready_o   (psum_ready_o),
    .res_o          (res_o),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_last_o     (res_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, psum_ready_o, 0);
    chk({tag, "_valid"}, res_valid_o, 0);
    chk({tag, "_res"},   res_o, 0);
    chk({tag, "_last"},  res_last_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_err"},   err_o, 0);
  endtask

  task automatic start_layer(input int n, input int t, input int s, input int r);
    cfg_node_num_i = 8'(n);
    cfg_tile_num_i = 4'(t);
    cfg_shift_i    = 4'(s);
    cfg_relu_i     = 1'(r);
    cfg_start_i    = 1'b1;
    @(negedge clk);
    cfg_start_i    = 1'b0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic expect_res(input int v, input int last);
    sb.push_back({1'(last), 8'(v)});
  endtask

  task automatic send(input int v);
    logic accepted;
    accepted     = 1'b0;
    psum_i       = 16'(v);
    psum_valid_i = 1'b1;
    for (int g = 0; g < 200 && !accepted; g++) begin
      accepted = psum_ready_o;
      @(negedge clk);
    end
    psum_valid_i = 1'b0;
    if (!accepted) chk("psum_accept_timeout", 32'(accepted), 1);
  endtask

  task automatic wait_done();
    logic found;
    found = 1'b0;
    for (int g = 0; g < 100 && !found; g++) begin
      if (done_o) found = 1'b1;
      else        @(negedge clk);
    end
    chk("done_seen", 32'(found), 1);
    chk("busy_in_done_cycle", busy_o, 1);
    chk("scoreboard_empty_at_done", sb.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
    chk("busy_after_done", busy_o, 0);
  endtask

  // Result monitor: pops the scoreboard on every output handshake and checks hold-under-stall.
  logic       stall = 1'b0;
  logic [8:0] held  = '0;
  always begin
    logic [8:0] exp;
    @(negedge clk);
    #1;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", res_valid_o, 1);
        chk("hold_data", {23'd0, res_last_o, res_o}, {23'd0, held});
      end
      if (res_valid_o && res_ready_i) begin
        if (sb.size() == 0) begin
          chk("result_without_expectation", sb.size(), 1);
        end else begin
          exp = sb.pop_front();
          chk("res", res_o, $signed(exp[7:0]));
          chk("last", res_last_o, exp[8]);
        end
      end
      stall = res_valid_o && !res_ready_i;
      held  = {res_last_o, res_o};
    end
  end

  initial begin
    rst = 1'b1; cfg_start_i = 1'b0; cfg_node_num_i = '0; cfg_tile_num_i = '0;
    cfg_shift_i = '0; cfg_relu_i = 1'b0; psum_i = '0; psum_valid_i = 1'b0; res_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single tile: saturation to 8 bits on both sides.
    start_layer(3, 1, 0, 0);
    expect_res(5, 0);    send(5);
    expect_res(127, 0);  send(200);
    expect_res(-128, 1); send(-300);
    wait_done();

    // Four tiles, shift 2 with round-half-up.
    start_layer(2, 4, 2, 0);
    for (int t = 0; t < 3; t++) begin
      chk("nonfinal_ready", psum_ready_o, 1);
      send(10);
      send(-3);
    end
    expect_res(10, 0); send(10);
    expect_res(-3, 1); send(-3);
    wait_done();

    // ReLU request: only honoured when compiled in.
    start_layer(2, 1, 0, 1);
`ifdef FC_RELU_EN
    expect_res(0, 0);
`else
    expect_res(-7, 0);
`endif
    send(-7);
    expect_res(9, 1); send(9);
    wait_done();

    // Output backpressure during the final tile.
    start_layer(4, 2, 1, 0);
    send(100); send(-50); send(3); send(60);
    res_ready_i = 1'b0;
    expect_res(60, 0);  send(20);
    expect_res(-75, 0); send(-100);
    chk("ready_drops_when_full", psum_ready_o, 0);
    repeat (3) @(negedge clk);
    chk("ready_stays_low", psum_ready_o, 0);
    chk("valid_while_stalled", res_valid_o, 1);
    res_ready_i = 1'b1;
    expect_res(4, 0);  send(5);
    expect_res(65, 1); send(70);
    wait_done();

    // Start with zero node count.
    cfg_node_num_i = 8'd0; cfg_tile_num_i = 4'd1; cfg_start_i = 1'b1;
    @(negedge clk);
    cfg_start_i = 1'b0;
    chk("zero_n_err", err_o, 1);
    chk("zero_n_busy", busy_o, 0);
    @(negedge clk);
    chk("zero_n_err_pulse", err_o, 0);
    chk("zero_n_busy_later", busy_o, 0);

    // Psum while idle.
    psum_i = 16'sd33; psum_valid_i = 1'b1;
    @(negedge clk);
    psum_valid_i = 1'b0;
    chk("idle_psum_err", err_o, 1);
    chk("idle_psum_no_result", res_valid_o, 0);
    @(negedge clk);
    chk("idle_psum_err_pulse", err_o, 0);

    // Start while busy is ignored.
    start_layer(2, 1, 0, 0);
    cfg_node_num_i = 8'd5; cfg_tile_num_i = 4'd3; cfg_start_i = 1'b1;
    @(negedge clk);
    cfg_start_i = 1'b0;
    chk("busy_start_err", err_o, 1);
    expect_res(11, 0);  send(11);
    expect_res(-20, 1); send(-20);
    wait_done();

    // Reset in the middle of tile 1 of a three-tile layer.
    start_layer(2, 3, 0, 0);
    send(1); send(2); send(3);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", done_o, 0);
    end
    start_layer(1, 1, 0, 0);
    expect_res(4, 1); send(4);
    chk("latency_valid", res_valid_o, 1);
    chk("latency_res", res_o, 4);
    wait_done();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
